// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter and fetch-request control.
//   Owns the fetch PC, issues fetch requests to instruction ROM with a valid/ready handshake,
//   applies branch redirects from ex, flushes if_id/id_ex for FLUSH_CYCLES cycles per redirect,
//   and holds the front end on an ex hold request or ROM back-pressure.
// Optional feature: define PC_MISALIGN_TRAP_EN to redirect misaligned jump targets to TRAP_ADDR
//   and report them on trap_o/trap_epc_o. Without it the target is word-aligned by dropping
//   bits [1:0] and the trap outputs are tied 0.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   jump_en_i    in   ex requests a redirect this cycle
//   jump_addr_i  in   redirect target from ex
//   hold_flag_i  in   ex requests a pipeline hold
//   inst_ready_i in   ROM accepts pc_o this cycle
//   pc_o         out  current fetch address
//   pc_valid_o   out  pc_o is a valid fetch request
//   flush_o      out  clear if_id and id_ex
//   hold_o       out  freeze if_id and id_ex
//   trap_o       out  one-cycle pulse after a misaligned jump
//   trap_epc_o   out  faulting jump target captured with trap_o
module pc_ctrl #(
   parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] TRAP_ADDR    = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   input  logic        inst_ready_i,
   output logic [31:0] pc_o,
   output logic        pc_valid_o,
   output logic        flush_o,
   output logic        hold_o,
   output logic        trap_o,
   output logic [31:0] trap_epc_o
);

   typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

   // The jump cycle itself is the first flush cycle, so the counter covers the remainder.
   localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] jump_target;
   logic        run;

   assign run = (state_q == StRun);

`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign;
   logic        trap_q, trap_d;
   logic [31:0] epc_q, epc_d;

   assign misalign    = |jump_addr_i[1:0];
   assign jump_target = misalign ? TRAP_ADDR : jump_addr_i;

   always_comb begin
      trap_d = 1'b0;
      epc_d  = epc_q;
      if (run && jump_en_i && misalign) begin
         trap_d = 1'b1;
         epc_d  = jump_addr_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         trap_q <= 1'b0;
         epc_q  <= 32'h0;
      end else begin
         trap_q <= trap_d;
         epc_q  <= epc_d;
      end
   end

   assign trap_o     = trap_q;
   assign trap_epc_o = epc_q;
`else
   logic unused_trap;

   assign jump_target = {jump_addr_i[31:2], 2'b00};
   assign unused_trap = ^{jump_addr_i[1:0], TRAP_ADDR};
   assign trap_o      = 1'b0;
   assign trap_epc_o  = 32'h0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         StBoot: state_d = StRun;
         StRun: begin
            if (jump_en_i) begin
               pc_d = jump_target;
               if (FLUSH_CYCLES > 1) begin
                  state_d = StFlush;
                  cnt_d   = FlushInit;
               end
            end else if (!hold_flag_i && inst_ready_i) begin
               pc_d = pc_q + 32'd4;
            end
         end
         StFlush: begin
            if (cnt_q <= 3'd1) begin
               state_d = StRun;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StBoot;
         pc_q    <= RESET_ADDR;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // flush_o and hold_o are mutually exclusive: hold is masked in the jump cycle and outside StRun.
   assign pc_o       = pc_q;
   assign pc_valid_o = run;
   assign flush_o    = (state_q == StFlush) || (run && jump_en_i);
   assign hold_o     = run && !jump_en_i && (hold_flag_i || !inst_ready_i);

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

   localparam logic [31:0] RA = 32'h0000_0000;
   localparam int unsigned FC = 2;
   localparam logic [31:0] TA = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_i;
   logic        inst_ready_i;
   logic [31:0] pc_o;
   logic        pc_valid_o;
   logic        flush_o;
   logic        hold_o;
   logic        trap_o;
   logic [31:0] trap_epc_o;

   int n_checks = 0;
   int n_fail   = 0;

   pc_ctrl #(
      .RESET_ADDR  (RA),
      .FLUSH_CYCLES(FC),
      .TRAP_ADDR   (TA)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .jump_en_i   (jump_en_i),
      .jump_addr_i (jump_addr_i),
      .hold_flag_i (hold_flag_i),
      .inst_ready_i(inst_ready_i),
      .pc_o        (pc_o),
      .pc_valid_o  (pc_valid_o),
      .flush_o     (flush_o),
      .hold_o      (hold_o),
      .trap_o      (trap_o),
      .trap_epc_o  (trap_epc_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: counts of remaining non-fetch cycles rather than an FSM.
   logic        m_ok = 1'b0;
   logic        m_boot;
   int          m_flush_left;
   logic [31:0] m_pc;
   logic        m_trap;
   logic [31:0] m_epc;

   function automatic logic [31:0] model_target(input logic [31:0] a);
`ifdef PC_MISALIGN_TRAP_EN
      return (a[1:0] != 2'b00) ? TA : a;
`else
      return a & ~32'h3;
`endif
   endfunction

   always @(posedge clk) begin
      m_trap <= 1'b0;
      if (rst) begin
         m_ok         <= 1'b1;
         m_boot       <= 1'b1;
         m_flush_left <= 0;
         m_pc         <= RA;
         m_epc        <= 32'h0;
      end else if (m_ok) begin
         if (m_boot) begin
            m_boot <= 1'b0;
         end else if (m_flush_left > 0) begin
            m_flush_left <= m_flush_left - 1;
         end else if (jump_en_i) begin
            m_pc         <= model_target(jump_addr_i);
            m_flush_left <= int'(FC) - 1;
`ifdef PC_MISALIGN_TRAP_EN
            if (jump_addr_i[1:0] != 2'b00) begin
               m_trap <= 1'b1;
               m_epc  <= jump_addr_i;
            end
`endif
         end else if (!hold_flag_i && inst_ready_i) begin
            m_pc <= m_pc + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         logic fetching;
         fetching = !m_boot && (m_flush_left == 0);
         chk("pc", pc_o, m_pc);
         chk("valid", 32'(pc_valid_o), 32'(fetching));
         chk("flush", 32'(flush_o), 32'((fetching && jump_en_i) || (m_flush_left > 0)));
         chk("hold", 32'(hold_o),
             32'(fetching && !jump_en_i && (hold_flag_i || !inst_ready_i)));
         chk("trap", 32'(trap_o), 32'(m_trap));
         chk("epc", trap_epc_o, m_epc);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic j, input logic [31:0] a, input logic h, input logic r);
      jump_en_i    = j;
      jump_addr_i  = a;
      hold_flag_i  = h;
      inst_ready_i = r;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      cyc();
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_valid", 32'(pc_valid_o), 32'd0);
      chk("rst_flush", 32'(flush_o), 32'd0);
      cyc();
      rst = 1'b0;
      #1;
      // Test 1: boot cycle then sequential fetch
      chk("t1_boot_valid", 32'(pc_valid_o), 32'd0);
      cyc();
      chk("t1_pc0", pc_o, 32'h0);
      chk("t1_valid", 32'(pc_valid_o), 32'd1);
      cyc();
      chk("t1_pc4", pc_o, 32'h4);
      cyc();
      chk("t1_pc8", pc_o, 32'h8);
      // Test 2: aligned jump, two flush cycles
      drive(1'b1, 32'h40, 1'b0, 1'b1);
      chk("t2_flush_n", 32'(flush_o), 32'd1);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk("t2_pc", pc_o, 32'h40);
      chk("t2_flush_n1", 32'(flush_o), 32'd1);
      chk("t2_valid_n1", 32'(pc_valid_o), 32'd0);
      cyc();
      chk("t2_flush_n2", 32'(flush_o), 32'd0);
      chk("t2_valid_n2", 32'(pc_valid_o), 32'd1);
      cyc();
      chk("t2_pc44", pc_o, 32'h44);
      // Test 3: hold for three cycles at 0x10
      drive(1'b1, 32'h10, 1'b0, 1'b1);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      cyc();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         chk("t3_hold", 32'(hold_o), 32'd1);
         chk("t3_pc", pc_o, 32'h10);
         cyc();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk("t3_release_pc", pc_o, 32'h10);
      chk("t3_release_hold", 32'(hold_o), 32'd0);
      cyc();
      chk("t3_pc14", pc_o, 32'h14);
      // Test 4: jump beats hold and back-pressure
      drive(1'b1, 32'h80, 1'b1, 1'b0);
      chk("t4_hold", 32'(hold_o), 32'd0);
      chk("t4_flush", 32'(flush_o), 32'd1);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk("t4_pc", pc_o, 32'h80);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("t4_bp_hold", 32'(hold_o), 32'd1);
      cyc();
      chk("t4_bp_pc", pc_o, 32'h80);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      cyc();
      chk("t4_pc84", pc_o, 32'h84);
      // Test 5: wraparound
      drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      cyc();
      chk("t5_pc_top", pc_o, 32'hFFFF_FFFC);
      cyc();
      chk("t5_pc_wrap", pc_o, 32'h0);
      // Test 6: misaligned target
      drive(1'b1, 32'h42, 1'b0, 1'b1);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
      chk("t6_pc", pc_o, 32'h100);
      chk("t6_trap", 32'(trap_o), 32'd1);
      chk("t6_epc", trap_epc_o, 32'h42);
`else
      chk("t6_pc", pc_o, 32'h40);
      chk("t6_trap", 32'(trap_o), 32'd0);
      chk("t6_epc", trap_epc_o, 32'h0);
`endif
      cyc();
      chk("t6_trap_pulse", 32'(trap_o), 32'd0);
      cyc();
      // Reset during flush
      drive(1'b1, 32'h20, 1'b0, 1'b1);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk("t6_in_flush", 32'(flush_o), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("t6_rst_pc", pc_o, RA);
      chk("t6_rst_flush", 32'(flush_o), 32'd0);
      chk("t6_rst_valid", 32'(pc_valid_o), 32'd0);
      cyc();
      chk("t6_run_pc", pc_o, RA);
      // Mixed traffic for the model
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 32'h0, i[2], !(i[1] & i[0]));
         cyc();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
